// File: rtl/pingpong_sample_buffer.sv
// Ping-pong input sample buffer: two banks of BLOCK_SIZE frames x NUM_CH channels,
// input backpressure, sticky overflow and a registered random-access read port.
// Optional drop counter output enabled by defining PINGPONG_DROP_CNT_EN.
module pingpong_sample_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int BLOCK_SIZE = 256,
    parameter int NUM_CH     = 1,
    localparam int AW = $clog2(BLOCK_SIZE),
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] sample_in,
    output logic                  ready_in,
    output logic                  ready_for_processing,
    output logic                  buffer_select,
    input  logic                  ready_ack,
    input  logic [AW-1:0]         rd_addr,
    input  logic [CW-1:0]         rd_ch,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [AW:0]           fill_level,
    output logic                  overflow,
    input  logic                  clear_overflow
`ifdef PINGPONG_DROP_CNT_EN
    ,
    output logic [15:0]           drop_count
`endif
);

    logic                  wb_q, wb_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         ch_q, ch_d;
    logic [1:0]            full_q, full_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] mem_q [2][BLOCK_SIZE][NUM_CH];

    logic accept, drop, ack_ok, last_ch, last_idx;

    assign ready_in             = !full_q[wb_q];
    assign accept               = valid_in && ready_in;
    assign drop                 = valid_in && !ready_in;
    assign ack_ok               = ready_ack && full_q[rd_bank_q];
    assign last_ch              = (ch_q == CW'(NUM_CH - 1));
    assign last_idx             = (idx_q == AW'(BLOCK_SIZE - 1));

    assign ready_for_processing = full_q[rd_bank_q];
    assign buffer_select        = rd_bank_q;
    assign fill_level           = {1'b0, idx_q};
    assign overflow             = ovf_q;
    assign rd_data              = rd_data_q;

    always_comb begin
        wb_d      = wb_q;
        rd_bank_d = rd_bank_q;
        idx_d     = idx_q;
        ch_d      = ch_q;
        full_d    = full_q;
        ovf_d     = ovf_q;
        if (accept) begin
            if (last_ch) begin
                ch_d = '0;
                if (last_idx) begin
                    // Block complete: hand the bank over and start filling the other one.
                    idx_d        = '0;
                    full_d[wb_q] = 1'b1;
                    wb_d         = !wb_q;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end else begin
                ch_d = ch_q + CW'(1);
            end
        end
        // A completing bank is never the acked bank (it was not full), so both may apply.
        if (ack_ok) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end
        if (drop)
            ovf_d = 1'b1;
        else if (clear_overflow)
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_q      <= 1'b0;
            rd_bank_q <= 1'b0;
            idx_q     <= '0;
            ch_q      <= '0;
            full_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            wb_q      <= wb_d;
            rd_bank_q <= rd_bank_d;
            idx_q     <= idx_d;
            ch_q      <= ch_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && accept)
            mem_q[wb_q][idx_q][ch_q] <= sample_in;
    end

    always_ff @(posedge clk) begin
        if (reset)
            rd_data_q <= '0;
        else if (32'(rd_ch) < NUM_CH)
            rd_data_q <= mem_q[rd_bank_q][rd_addr][rd_ch];
        else
            rd_data_q <= '0;
    end

`ifdef PINGPONG_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (reset)
            drop_cnt_q <= '0;
        else if (clear_overflow)
            drop_cnt_q <= drop ? 16'd1 : 16'd0;
        else if (drop && drop_cnt_q != 16'hFFFF)
            drop_cnt_q <= drop_cnt_q + 16'd1;
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule
